// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues imem reads and presents {pc, instr, valid} to IF/ID
// FETCH_PERF_EN adds fetch_cnt/stall_cnt performance counters
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            if_valid,
  output logic            if_misaligned
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     stall_cnt
`endif
);
  state_t state, state_nxt;
  logic [XLEN-1:0] fetch_pc, resp_pc, tgt;
  logic resp_valid, resp_mis, boot, redir, hold;
  assign boot  = state == S_BOOT;
  assign redir = redirect_en && !boot;
  assign hold  = stall && !boot && !redirect_en;
  assign tgt   = {redirect_pc[XLEN-1:2], 2'b00};
  always_ff @(posedge clk)
    state <= rst ? S_BOOT : state_nxt;
  always_comb
    state_nxt = redir ? S_RUN : hold ? S_HOLD : S_RUN;
  // replaying resp_pc while stalled keeps imem_rdata on the held instruction
  always_comb begin
    imem_addr     = redir ? tgt : hold ? resp_pc : fetch_pc;
    if_pc         = resp_pc;
    if_instr      = imem_rdata;
    if_valid      = resp_valid;
    if_misaligned = resp_mis;
  end
  always_ff @(posedge clk)
    if (rst) begin
      fetch_pc   <= RESET_PC;
      resp_pc    <= '0;
      resp_valid <= 1'b0;
      resp_mis   <= 1'b0;
    end else if (redir) begin
      resp_pc    <= tgt;
      fetch_pc   <= tgt + XLEN'(INSTR_BYTES);
      resp_valid <= 1'b1;
      resp_mis   <= |redirect_pc[1:0];
    end else if (!hold) begin
      resp_pc    <= fetch_pc;
      fetch_pc   <= fetch_pc + XLEN'(INSTR_BYTES);
      resp_valid <= 1'b1;
      resp_mis   <= 1'b0;
    end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk)
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      fetch_cnt <= fetch_cnt + 32'(state == S_RUN && !stall && !redirect_en && resp_valid);
      stall_cnt <= stall_cnt + 32'(stall && !redirect_en);
    end
`endif
endmodule
